// File: rtl/vmem_pkg.sv
// Shared definitions for the vector memory unit: FSM state encoding and default geometry.
package vmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_LAST,
        DONE
    } vmem_state_e;

    localparam int unsigned VMEM_N     = 16;
    localparam int unsigned VMEM_LANES = 16;
    localparam int unsigned VMEM_AW    = 10;

endpackage

// File: rtl/vmem_lane_buffer.sv
// LANES x N register array with a write enable per lane; used both as the
// store staging buffer and as the load capture register.
module vmem_lane_buffer #(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          we_i,
    input  logic [LANES-1:0][N-1:0]   d_i,
    output logic [LANES-1:0][N-1:0]   q_o
);

    logic [LANES-1:0][N-1:0] lanes_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (we_i[i]) lanes_q[i] <= d_i[i];
            end
        end
    end

    assign q_o = lanes_q;

endmodule

// File: rtl/vector_mem_unit.sv
// Serialises a LANES-wide vector load/store onto a scalar synchronous RAM,
// one lane per cycle, stalling the pipeline for the duration of the transfer.
module vector_mem_unit
    import vmem_pkg::*;
#(
    parameter int unsigned N     = VMEM_N,
    parameter int unsigned LANES = VMEM_LANES,
    parameter int unsigned AW    = VMEM_AW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_write_i,
    input  logic                      mem_read_i,
    input  logic [LANES-1:0][N-1:0]   addr_i,
    input  logic [LANES-1:0][N-1:0]   wdata_i,
    output logic [LANES-1:0][N-1:0]   rdata_o,
    output logic                      stall_o,
    output logic                      done_o,
    output logic [AW-1:0]             ram_addr_o,
    output logic                      ram_we_o,
    output logic [N-1:0]              ram_wdata_o,
    input  logic [N-1:0]              ram_rdata_i
);

    localparam int unsigned    CW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LANES - 1);

    vmem_state_e             state_q;
    logic [CW-1:0]           cnt_q;
    logic [AW-1:0]           base_q;
    logic                    done_q;

    logic [LANES-1:0]        wbuf_we;
    logic [LANES-1:0][N-1:0] wbuf_q;
    logic [LANES-1:0]        rbuf_we;
    logic [LANES-1:0][N-1:0] rbuf_d;
    logic [CW-1:0]           cap_lane;
    logic                    cap_en;
    logic                    unused_addr;

    assign unused_addr = ^addr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_write_i) begin
                        state_q <= WRITE;
                        cnt_q   <= '0;
                        base_q  <= addr_i[0][AW-1:0];
                    end else if (mem_read_i) begin
                        state_q <= READ;
                        cnt_q   <= '0;
                        base_q  <= addr_i[0][AW-1:0];
                    end
                end
                WRITE: begin
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // Counter parks on the last lane so READ_LAST can capture it.
                READ: begin
                    if (cnt_q == LAST) state_q <= READ_LAST;
                    else               cnt_q   <= cnt_q + CW'(1);
                end
                READ_LAST: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data lags the issued address by one cycle, so capture trails the counter.
    always_comb begin
        cap_en   = (state_q == READ_LAST) || ((state_q == READ) && (cnt_q != '0));
        cap_lane = (state_q == READ_LAST) ? cnt_q : cnt_q - CW'(1);
        rbuf_we  = '0;
        if (cap_en) rbuf_we[cap_lane] = 1'b1;
        for (int unsigned i = 0; i < LANES; i++) rbuf_d[i] = ram_rdata_i;
        wbuf_we  = {LANES{(state_q == IDLE) && mem_write_i}};
    end

    vmem_lane_buffer #(.N(N), .LANES(LANES)) u_wbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (wbuf_we),
        .d_i   (wdata_i),
        .q_o   (wbuf_q)
    );

    vmem_lane_buffer #(.N(N), .LANES(LANES)) u_rbuf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (rbuf_we),
        .d_i   (rbuf_d),
        .q_o   (rdata_o)
    );

    assign ram_addr_o  = base_q + AW'(cnt_q);
    assign ram_we_o    = (state_q == WRITE);
    assign ram_wdata_o = wbuf_q[cnt_q];
    assign done_o      = done_q;
    assign stall_o     = ((state_q == IDLE) && (mem_read_i || mem_write_i))
                       || (state_q == WRITE) || (state_q == READ) || (state_q == READ_LAST);

endmodule

// File: tb/tb_vector_mem_unit.sv
// Self-checking bench: behavioural RAM plus a shadow-memory reference model of vector transfers.
module tb_vector_mem_unit;

    localparam int N     = 16;
    localparam int LANES = 16;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int VW    = LANES * N;

    typedef logic [LANES-1:0][N-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_write_i = 1'b0;
    logic          mem_read_i = 1'b0;
    vec_t          addr_i = '0;
    vec_t          wdata_i = '0;
    vec_t          rdata_o;
    logic          stall_o;
    logic          done_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [N-1:0]  ram_wdata_o;
    logic [N-1:0]  ram_rdata_i;

    logic [N-1:0]  ram     [DEPTH];
    logic [N-1:0]  ref_mem [DEPTH];
    vec_t          exp_rdata;

    int checks = 0;
    int failures = 0;
    int stall_cnt, done_cnt, we_cnt;
    bit mon_en = 1'b0;

    vector_mem_unit #(.N(N), .LANES(LANES), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_write_i (mem_write_i),
        .mem_read_i  (mem_read_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= ram[ram_addr_o];
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            stall_cnt += int'(stall_o);
            done_cnt  += int'(done_o);
            we_cnt    += int'(ram_we_o);
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input int base, input vec_t wd, input int nlanes);
        for (int k = 0; k < nlanes; k++) ref_mem[(base + k) % DEPTH] = wd[k];
    endtask

    function automatic vec_t model_load(input int base);
        vec_t v;
        for (int k = 0; k < LANES; k++) v[k] = ref_mem[(base + k) % DEPTH];
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < LANES; k++) v[k] = N'($urandom);
        return v;
    endfunction

    task automatic check_ram(input string tag);
        int mism = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
        check(tag, VW'(mism), '0);
    endtask

    // Requests are held until stall_o drops, as a stalled pipeline would.
    task automatic xfer(input string tag, input bit wr, input bit rd, input int base, input vec_t wd);
        vec_t a;
        vec_t rd_at_done;
        logic done_at_drop;
        int cyc = 0;
        bit timeout = 0;
        a = rand_vec();
        a[0][AW-1:0] = AW'(base);
        @(negedge clk);
        stall_cnt = 0; done_cnt = 0; we_cnt = 0; mon_en = 1'b1;
        mem_write_i = wr; mem_read_i = rd; addr_i = a; wdata_i = wd;
        forever begin
            #2;
            if (!stall_o) break;
            cyc++;
            if (cyc > 60) begin timeout = 1; break; end
            @(negedge clk);
        end
        rd_at_done = rdata_o;
        done_at_drop = done_o;
        mem_write_i = 1'b0; mem_read_i = 1'b0;
        repeat (4) @(negedge clk);
        #2 mon_en = 1'b0;
        check({tag, "_timeout"}, VW'(timeout), '0);
        check({tag, "_done_at_drop"}, VW'(done_at_drop), VW'(1));
        check({tag, "_done_pulses"}, VW'(done_cnt), VW'(1));
        if (wr) begin
            model_store(base, wd, LANES);
            check({tag, "_we_cycles"}, VW'(we_cnt), VW'(LANES));
            check({tag, "_stall_cycles"}, VW'(stall_cnt), VW'(LANES + 1));
        end else if (rd) begin
            exp_rdata = model_load(base);
            check({tag, "_we_cycles"}, VW'(we_cnt), '0);
            check({tag, "_stall_cycles"}, VW'(stall_cnt), VW'(LANES + 2));
        end
        check({tag, "_rdata"}, rd_at_done, exp_rdata);
        check({tag, "_rdata_hold"}, rdata_o, exp_rdata);
        check_ram({tag, "_ram"});
    endtask

    initial begin
        vec_t wd;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = N'($urandom);
            ref_mem[i] = ram[i];
        end
        exp_rdata = '0;

        // Reset state.
        mem_write_i = 1'b1;
        #12;
        check("rst_rdata", rdata_o, '0);
        check("rst_done", VW'(done_o), '0);
        check("rst_we", VW'(ram_we_o), '0);
        mem_write_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_stall", VW'(stall_o), '0);

        // Directed store / load at base 0x005.
        for (int k = 0; k < LANES; k++) wd[k] = N'(16'h1000 + k);
        xfer("store_005", 1'b1, 1'b0, 'h005, wd);
        xfer("load_005", 1'b0, 1'b1, 'h005, rand_vec());
        check("load_005_value", rdata_o, VW'(wd));

        // Address wrap: lanes 6..15 land at 0x000..0x009.
        xfer("store_wrap", 1'b1, 1'b0, 'h3FA, rand_vec());
        xfer("load_wrap", 1'b0, 1'b1, 'h3FA, rand_vec());

        // Both requests: store wins, rdata_o untouched.
        xfer("both_req", 1'b1, 1'b1, 'h100, rand_vec());

        // Back-to-back load after store at the same base.
        xfer("b2b_store", 1'b1, 1'b0, 'h200, rand_vec());
        xfer("b2b_load", 1'b0, 1'b1, 'h200, rand_vec());

        // Randomised transfer mix.
        for (int t = 0; t < 10; t++) begin
            int op = int'($urandom_range(0, 2));
            int base = int'($urandom_range(0, DEPTH - 1));
            if (op == 0)      xfer("rnd_store", 1'b1, 1'b0, base, rand_vec());
            else if (op == 1) xfer("rnd_load",  1'b0, 1'b1, base, rand_vec());
            else              xfer("rnd_both",  1'b1, 1'b1, base, rand_vec());
        end

        // Reset during WRITE lane 7 aborts the store.
        wd = rand_vec();
        @(negedge clk);
        stall_cnt = 0; done_cnt = 0; we_cnt = 0; mon_en = 1'b1;
        addr_i = '0; addr_i[0][AW-1:0] = AW'('h050);
        wdata_i = wd; mem_write_i = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_we_lane7", VW'(ram_we_o), VW'(1));
        mem_write_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_we", VW'(ram_we_o), '0);
        check("abort_stall", VW'(stall_o), '0);
        check("abort_rdata", rdata_o, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #2 mon_en = 1'b0;
        exp_rdata = '0;
        model_store('h050, wd, 7);
        check("abort_we_cycles", VW'(we_cnt), VW'(7));
        check("abort_done", VW'(done_cnt), '0);
        check_ram("abort_ram");

        // Unit still operational after the abort.
        xfer("post_abort_load", 1'b0, 1'b1, 'h050, rand_vec());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_mem_unit.md
VECTOR_MEM_UNIT -- requirements
Module: vector_mem_unit

Interface
REQ-001 Parameter N shall default to 16 and set the lane width in bits.
REQ-002 Parameter LANES shall default to 16 and set the lanes per vector.
REQ-003 Parameter AW shall default to 10 and set the scalar RAM address width.
REQ-004 CLK  in  1  is the single clock, rising-edge.
REQ-005 RST  in  1  is the reset: asynchronous, active-low.
REQ-006 mem_write_i  in  1  is the store request from the M stage (MemWriteM).
REQ-007 mem_read_i  in  1  is the load request from the M stage (MemtoRegM).
REQ-008 addr_i  in  [LANES-1:0][N-1:0]  is ALUResultM; lane 0 bits [AW-1:0] give the base address.
REQ-009 wdata_i  in  [LANES-1:0][N-1:0]  is the store vector (writeDataM).
REQ-010 rdata_o  out  [LANES-1:0][N-1:0]  is the load vector (drives RDM).
REQ-011 stall_o  out  1  freezes Fetch, Decode, Execute and M pipe registers while high.
REQ-012 done_o  out  1  is a one-cycle pulse when a transfer completes.
REQ-013 ram_addr_o  out  AW  is the scalar RAM address.
REQ-014 ram_we_o  out  1  is the scalar RAM write enable.
REQ-015 ram_wdata_o  out  N  is the scalar RAM write data.
REQ-016 ram_rdata_i  in  N  is the scalar RAM read data, valid one cycle after the address.

Function
REQ-017 FSM states shall be IDLE, WRITE, READ, READ_LAST and DONE.
REQ-018 In IDLE, mem_write_i=1 shall go to WRITE with lane counter 0; else mem_read_i=1 shall go to READ; else stay.
REQ-019 When both requests are high in IDLE, write shall take priority and the read shall be dropped.
REQ-020 Base shall be latched on leaving IDLE; wdata_i shall be latched on entering WRITE.
REQ-021 WRITE lane k shall drive ram_we_o=1, ram_addr_o=(base+k) mod 2^AW and ram_wdata_o=lane k, for k=0..LANES-1, one per cycle.
REQ-022 After lane LANES-1, WRITE shall go to DONE; store occupancy is LANES+2 cycles including the IDLE accept and DONE.
REQ-023 READ lane k shall drive ram_addr_o=(base+k) mod 2^AW with ram_we_o=0, and the cycle after shall capture ram_rdata_i into lane k.
REQ-024 After issuing lane LANES-1, READ shall go to READ_LAST, capture the final lane, then go to DONE.
REQ-025 stall_o shall equal (IDLE and (mem_read_i or mem_write_i)) or WRITE or READ or READ_LAST; it is combinational and low in DONE.
REQ-026 DONE shall assert done_o for exactly one cycle and return to IDLE.
REQ-027 rdata_o shall update only on lane captures and hold its value otherwise, including during stores.
REQ-028 Request inputs shall be ignored outside IDLE.
REQ-029 Lane counter shall be log2(LANES) bits; address arithmetic shall wrap modulo 2^AW.
REQ-030 ram_we_o shall be 0 in every state except WRITE.

Reset
REQ-031 RST low shall force IDLE, lane counter 0, base 0, write buffer 0, rdata_o 0, done_o 0 and ram_we_o 0, immediately and asynchronously.
REQ-032 Reset mid-transfer shall abort it; RAM lanes already written stay written, and no done_o pulse shall occur.

Structure
REQ-033 The state enum, LANES and AW defaults shall live in a shared package, vmem_pkg.
REQ-034 One sub-module, vmem_lane_buffer, shall hold the LANES×N register array with per-lane write enable, serving both the store buffer and the load capture.

Verification
REQ-035 Store to base 0x005 with lane k = 0x1000+k -> 16 cycles of ram_we_o; RAM[0x005+k]=0x1000+k; stall_o high 17 cycles; done_o pulses once.
REQ-036 Load from base 0x005 after the store -> rdata_o lane k = 0x1000+k at DONE; stall_o high 18 cycles.
REQ-037 Store at base 0x3FA (AW=10) -> lanes 6..15 land at 0x000..0x009.
REQ-038 mem_read_i and mem_write_i both high -> only a store executes; rdata_o is unchanged.
REQ-039 RST low at WRITE lane 7 -> IDLE next edge, RAM[base+8..] untouched, no done_o, stall_o low.
REQ-040 Back-to-back load after store, requests held until stall_o drops -> each executes once; no duplicate transfer after DONE.
